cross_bar_nxm: RTL

- Parametrised NM-master x NS-slave crossbar for the bus_if protocol (req/addr/cmd/wdata, ack, resp/rdata).
- Each slave port has its own arbiter and FSM, so transactions to different slaves proceed concurrently.
- Arbitration is round-robin per slave. Read data is returned to the owning master.
- Sits between the bus masters and the address-decoded slave regions. Next generation of the 2x2 single-transaction crossbar.

---
 rtl/cross_bar_nxm.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/cross_bar_nxm.sv
// cross_bar_nxm: NM-master x NS-slave crossbar for the bus_if protocol.
// Each slave port has its own round-robin arbiter and IDLE/GRANT/RDWAIT FSM,
// so traffic to different slaves proceeds concurrently. The slave index is
// taken from the top log2(NS) address bits; the address is forwarded unchanged.
// Optional: define XBAR_RD_TIMEOUT_EN to abandon reads that get no response
// within TO_CYCLES cycles (the master then sees an all-ones read response).

module cross_bar_nxm #(
  parameter int NM        = 2,
  parameter int NS        = 2,
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int TO_CYCLES = 256
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NM-1:0]    m_req,
  input  logic [NM*AW-1:0] m_addr,
  input  logic [NM-1:0]    m_cmd,
  input  logic [NM*DW-1:0] m_wdata,
  output logic [NM-1:0]    m_ack,
  output logic [NM-1:0]    m_resp,
  output logic [NM*DW-1:0] m_rdata,
  output logic [NS-1:0]    s_req,
  output logic [NS*AW-1:0] s_addr,
  output logic [NS-1:0]    s_cmd,
  output logic [NS*DW-1:0] s_wdata,
  input  logic [NS-1:0]    s_ack,
  input  logic [NS-1:0]    s_resp,
  input  logic [NS*DW-1:0] s_rdata
);

  localparam int SW = $clog2(NS);
  localparam int MW = $clog2(NM);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_GRANT  = 2'd1;
  localparam logic [1:0] ST_RDWAIT = 2'd2;

  logic [1:0]    r_state     [NS];
  logic [MW-1:0] r_owner     [NS];
  logic [MW-1:0] r_ptr       [NS];
  logic [1:0]    w_nextState [NS];
  logic [MW-1:0] w_pick      [NS];
  logic [NS-1:0] w_found;
  logic [NM-1:0] w_busy;
  logic [SW-1:0] w_dec       [NM];

`ifdef XBAR_RD_TIMEOUT_EN
  localparam int TO_W = $clog2(TO_CYCLES + 1);
  logic [TO_W-1:0] r_toCnt [NS];
`endif

  // Slave index each master is currently addressing (top address bits).
  always_comb begin
    for (int m = 0; m < NM; m++) begin
      w_dec[m] = m_addr[m*AW + AW - 1 -: SW];
    end
  end

  // Masters owned by a non-idle slave FSM may not be granted again elsewhere.
  always_comb begin
    w_busy = '0;
    for (int s = 0; s < NS; s++) begin
      if (r_state[s] != ST_IDLE) begin
        w_busy[r_owner[s]] = 1'b1;
      end
    end
  end

  // Round-robin pick per slave: first eligible master after the last owner.
  always_comb begin
    logic [MW-1:0] idx;
    idx     = '0;
    w_found = '0;
    for (int s = 0; s < NS; s++) begin
      w_pick[s] = r_ptr[s];
      for (int i = 1; i <= NM; i++) begin
        idx = MW'((int'(r_ptr[s]) + i) % NM);
        if (!w_found[s] && m_req[idx] && !w_busy[idx] && (w_dec[idx] == SW'(s))) begin
          w_found[s] = 1'b1;
          w_pick[s]  = idx;
        end
      end
    end
  end

  // Per-slave next state plus the combinational master/slave routing.
  always_comb begin
    s_req   = '0;
    s_addr  = '0;
    s_cmd   = '0;
    s_wdata = '0;
    m_ack   = '0;
    m_resp  = '0;
    m_rdata = '0;
    for (int s = 0; s < NS; s++) begin
      w_nextState[s] = r_state[s];
      case (r_state[s])
        ST_IDLE: begin
          if (w_found[s]) begin
            w_nextState[s] = ST_GRANT;
          end
        end
        ST_GRANT: begin
          s_req[s]              = m_req[r_owner[s]];
          s_addr[s*AW +: AW]    = m_addr[r_owner[s]*AW +: AW];
          s_cmd[s]              = m_cmd[r_owner[s]];
          s_wdata[s*DW +: DW]   = m_wdata[r_owner[s]*DW +: DW];
          if (!m_req[r_owner[s]]) begin
            w_nextState[s] = ST_IDLE;
          end else if (s_ack[s]) begin
            m_ack[r_owner[s]] = 1'b1;
            if (m_cmd[r_owner[s]]) begin
              w_nextState[s] = ST_IDLE;
            end else if (s_resp[s]) begin
              m_resp[r_owner[s]]              = 1'b1;
              m_rdata[r_owner[s]*DW +: DW]    = s_rdata[s*DW +: DW];
              w_nextState[s]                  = ST_IDLE;
            end else begin
              w_nextState[s] = ST_RDWAIT;
            end
          end
        end
        ST_RDWAIT: begin
          m_resp[r_owner[s]]           = s_resp[s];
          m_rdata[r_owner[s]*DW +: DW] = s_rdata[s*DW +: DW];
          if (s_resp[s]) begin
            w_nextState[s] = ST_IDLE;
`ifdef XBAR_RD_TIMEOUT_EN
          end else if (r_toCnt[s] == TO_W'(TO_CYCLES)) begin
            m_resp[r_owner[s]]           = 1'b1;
            m_rdata[r_owner[s]*DW +: DW] = '1;
            w_nextState[s]               = ST_IDLE;
`endif
          end
        end
        default: begin
          w_nextState[s] = ST_IDLE;
        end
      endcase
    end
  end

  // State, owner and round-robin pointer registers; pointer starts so master 0 wins first.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int s = 0; s < NS; s++) begin
        r_state[s] <= ST_IDLE;
        r_owner[s] <= '0;
        r_ptr[s]   <= MW'(NM - 1);
      end
    end else begin
      for (int s = 0; s < NS; s++) begin
        r_state[s] <= w_nextState[s];
        if ((r_state[s] == ST_IDLE) && w_found[s]) begin
          r_owner[s] <= w_pick[s];
          r_ptr[s]   <= w_pick[s];
        end
      end
    end
  end

`ifdef XBAR_RD_TIMEOUT_EN
  // Read-wait cycle counter: held at zero outside RDWAIT, counts cycles spent inside.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int s = 0; s < NS; s++) begin
        r_toCnt[s] <= '0;
      end
    end else begin
      for (int s = 0; s < NS; s++) begin
        if (r_state[s] != ST_RDWAIT) begin
          r_toCnt[s] <= '0;
        end else if (r_toCnt[s] != TO_W'(TO_CYCLES)) begin
          r_toCnt[s] <= r_toCnt[s] + 1'b1;
        end
      end
    end
  end
`endif

endmodule
